nibble_serial_adder: RTL and testbench

// - Multi-nibble add/subtract engine: takes WIDTH-bit operands via valid/ready and

---
 rtl/adder_pkg.sv | 21 ++
 rtl/bit_4_carry_lookahead.sv | 40 ++++
 rtl/nibble_serial_adder.sv | 154 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared constants and FSM state encoding for the nibble-serial
//                add/subtract engine.
//                NIBBLE_W - width of one adder slice (4 bits)
//                state_t  - engine FSM states (2'd3 is unused)
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_4_carry_lookahead.sv
`default_nettype none
// ============================================================================
//  Module      : bit_4_carry_lookahead
//  Description : 4-bit carry-lookahead adder, purely combinational.
//  Ports       : a, b  in  4  addends
//                c_0   in  1  carry in
//                s     out 4  sum
//                c_4   out 1  carry out of bit 3
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_4_carry_lookahead (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_0,
  output logic [3:0] s,
  output logic       c_4
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is expanded directly from c_0 so no ripple path exists.
  assign w_c[0] = c_0;
  assign w_c[1] = w_g[0] | (w_p[0] & c_0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_0);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_0);

  assign s   = w_p ^ w_c[3:0];
  assign c_4 = w_c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit add/subtract engine that walks the operands
//                LSB-first one nibble per clock through a single 4-bit
//                carry-lookahead adder, keeping the carry in a register.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                in_valid, in_ready  operand handshake (ready only in IDLE)
//                a, b, cin, sub      operands; sub=1 computes a-b, cin ignored
//                out_valid,out_ready result handshake (valid only in DONE)
//                sum, cout, ovf      result, carry out (sub: 1 = no borrow),
//                                    signed overflow
//                busy                high while running or holding a result
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, minimum 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [IDX_W+1:0]  w_base;  // bit offset of the current nibble
  logic              w_last;
  logic [3:0]        w_s;
  logic              w_c4;

  assign w_base = {r_idx, 2'b00};
  assign w_last = (r_idx == C_LAST_IDX);

  bit_4_carry_lookahead u_cla (
    .a   (r_a[w_base +: NIBBLE_W]),
    .b   (r_b[w_base +: NIBBLE_W]),
    .c_0 (r_carry),
    .s   (w_s),
    .c_4 (w_c4)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, nibble sequencing, result collection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b once here and seed carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: NIBBLE_W] <= w_s;
          r_carry                   <= w_c4;
          r_idx                     <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_c4;
            // Overflow: both addends share a sign the result does not.
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              cin = 1'b0;
  logic              sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic              busy;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands; returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
    logic [16:0] full;
    logic [15:0] r;
    logic        co;
    int          sr;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sr = int'($signed(x)) - int'($signed(y));
    end else begin
      full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      r    = full[15:0];
      co   = full[16];
      sr   = int'($signed(x)) + int'($signed(y)) + int'(ci);
    end
    return {(sr > 32767 || sr < -32768), co, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (caller guarantees IDLE), then scramble them.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic s);
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!out_valid && cycles < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy/vld/busy=%b sum=%h cout=%b ovf=%b, want 100 0000 0 0",
               {in_ready, out_valid, busy}, sum, cout, ovf);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
    logic [15:0] vb [7] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0007, 16'h0001};
    logic        vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] ve [7] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b00, 16'h0100},
                            {2'b10, 16'h8000}, {2'b11, 16'h0000}, {2'b00, 16'hFFFE},
                            {2'b11, 16'h7FFF}};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      start_op(va[i], vb[i], vc[i], vs[i]);
      wait_done(cyc);
      total++;
      if (cyc !== LAT || {ovf, cout, sum} !== ve[i]) begin
        bad++;
        $display("FAIL directed[%0d]: latency=%0d {ovf,cout,sum}=%h, want latency=%0d %h",
                 i, cyc, {ovf, cout, sum}, LAT, ve[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL directed_release[%0d]: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        ci, s;
    logic [17:0] exp_v;
    int          cyc, hold;
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom); s = 1'($urandom);
      if (i % 5 == 0) y = ~x;  // long carry chains
      exp_v = ref_model(x, y, ci, s);
      start_op(x, y, ci, s);
      wait_done(cyc);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) tick();
      total++;
      if (cyc !== LAT || out_valid !== 1'b1 || {ovf, cout, sum} !== exp_v) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b latency=%0d vld=%b got=%h want=%h",
                 i, x, y, ci, s, cyc, out_valid, {ovf, cout, sum}, exp_v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(cyc);
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333 || busy !== 1'b1) begin
        bad++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b busy=%b sum=%h, want 1 0 1 3333",
                 i, out_valid, in_ready, busy, sum);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_next_accept: in_ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    wait_done(cyc);
    total++;
    if (cyc !== LAT || sum !== 16'h1010 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL bp_second_op: latency=%0d sum=%h cout=%b ovf=%b, want %0d 1010 0 0",
               cyc, sum, cout, ovf, LAT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    start_op(16'hABCD, 16'h1357, 1'b1, 1'b0);
    tick();          // now in the 2nd RUN cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_op: rdy/vld/busy=%b sum=%h cout=%b ovf=%b, want 100 0000 0 0",
               {in_ready, out_valid, busy}, sum, cout, ovf);
    end
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc !== LAT || sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_op: latency=%0d sum=%h cout=%b ovf=%b, want %0d 5555 0 0",
               cyc, sum, cout, ovf, LAT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // in_valid and out_ready held high: one op every LAT+2 cycles.
  task automatic test_back_to_back();
    logic [15:0] x, y;
    logic        ci, s;
    logic [17:0] exp_v;
    int          cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom); s = 1'($urandom);
      exp_v = ref_model(x, y, ci, s);
      in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
      tick();
      a = 16'($urandom); b = 16'($urandom);
      wait_done(cyc);
      total++;
      if (cyc !== LAT || {ovf, cout, sum} !== exp_v) begin
        bad++;
        $display("FAIL back_to_back[%0d]: latency=%0d got=%h want=%h", i, cyc, {ovf, cout, sum}, exp_v);
      end
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle[%0d]: rdy=%b vld=%b busy=%b, want 1 0 0", i, in_ready, out_valid, busy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
